// File: rtl/uart_hex_printer.sv
// uart_hex_printer
//   Turns a binary value into ASCII hex text ("0x", fixed-width uppercase
//   digits, CR LF) and streams it one byte at a time to a UART transmitter.
//   A one-entry pending slot lets the next value queue while a message prints.
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   value_i        value to print (WIDTH bits)
//   value_valid_i  value_i is offered
//   value_ready_o  a value can be accepted (pending slot empty)
//   data_o         ASCII byte to the UART
//   data_valid_o   data_o is valid
//   ready_i        UART accepts a byte
//   busy_o         a message is in progress
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | nothing printing, waiting for a value
// S_PFX0  | presenting '0' of the prefix
// S_PFX1  | presenting 'x' of the prefix
// S_DIGIT | presenting hex digit selected by r_cnt (MSB first)
// S_CR    | presenting carriage return
// S_LF    | presenting line feed

module uart_hex_printer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PREFIX_EN  = 1,
    parameter int unsigned NEWLINE_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value_i,
    input  logic             value_valid_i,
    output logic             value_ready_o,
    output logic [7:0]       data_o,
    output logic             data_valid_o,
    input  logic             ready_i,
    output logic             busy_o
);

    localparam int unsigned DIGITS = WIDTH / 4;
    localparam int unsigned CW     = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PFX0,
        S_PFX1,
        S_DIGIT,
        S_CR,
        S_LF
    } state_t;

    localparam state_t S_FIRST = (PREFIX_EN != 0) ? S_PFX0 : S_DIGIT;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_pend;
    logic             r_pend_valid;

    state_t           w_nxt_state;
    logic [CW-1:0]    w_nxt_cnt;
    logic [WIDTH-1:0] w_nxt_active;
    logic [WIDTH-1:0] w_nxt_pend;
    logic             w_nxt_pend_valid;
    logic             w_accept;
    logic             w_hs;
    logic             w_last;
    logic [3:0]       w_nxt_nib;
    logic [7:0]       w_nxt_char;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        // 8'h37 + 10 = 'A'
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign value_ready_o = !r_pend_valid;
    assign w_accept      = value_valid_i && !r_pend_valid;
    assign w_hs          = data_valid_o && ready_i;
    assign w_last        = (r_state == S_LF) ||
                           ((r_state == S_DIGIT) && (r_cnt == '0) && (NEWLINE_EN == 0));

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_cnt        = r_cnt;
        w_nxt_active     = r_active;
        w_nxt_pend       = r_pend;
        w_nxt_pend_valid = r_pend_valid;

        if (r_state == S_IDLE) begin
            if (w_accept) begin
                w_nxt_active = value_i;
                w_nxt_state  = S_FIRST;
                w_nxt_cnt    = CNT_TOP;
            end
        end else begin
            if (w_hs) begin
                if (w_last) begin
                    // pending value wins over a fresh offer; with the slot
                    // full no offer can be accepted anyway
                    if (r_pend_valid) begin
                        w_nxt_active     = r_pend;
                        w_nxt_pend_valid = 1'b0;
                        w_nxt_state      = S_FIRST;
                        w_nxt_cnt        = CNT_TOP;
                    end else if (w_accept) begin
                        w_nxt_active = value_i;
                        w_nxt_state  = S_FIRST;
                        w_nxt_cnt    = CNT_TOP;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end else begin
                    case (r_state)
                        S_PFX0:  w_nxt_state = S_PFX1;
                        S_PFX1: begin
                            w_nxt_state = S_DIGIT;
                            w_nxt_cnt   = CNT_TOP;
                        end
                        S_DIGIT: begin
                            if (r_cnt != '0) begin
                                w_nxt_cnt = r_cnt - CW'(1);
                            end else begin
                                w_nxt_state = S_CR;
                            end
                        end
                        S_CR:    w_nxt_state = S_LF;
                        default: w_nxt_state = r_state;
                    endcase
                end
            end
            // an offer taken on the last handshake went straight to active
            if (w_accept && !(w_hs && w_last)) begin
                w_nxt_pend       = value_i;
                w_nxt_pend_valid = 1'b1;
            end
        end
    end

    // the output byte is built from next-state values so data_o is registered
    // yet already correct on the cycle after each handshake (no bubbles)
    assign w_nxt_nib = 4'(w_nxt_active >> {w_nxt_cnt, 2'b00});

    always_comb begin
        w_nxt_char = 8'h00;
        case (w_nxt_state)
            S_PFX0:  w_nxt_char = 8'h30;
            S_PFX1:  w_nxt_char = 8'h78;
            S_DIGIT: w_nxt_char = hex_char(w_nxt_nib);
            S_CR:    w_nxt_char = 8'h0D;
            S_LF:    w_nxt_char = 8'h0A;
            default: w_nxt_char = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_active     <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            data_o       <= 8'h00;
            data_valid_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_cnt        <= w_nxt_cnt;
            r_active     <= w_nxt_active;
            r_pend       <= w_nxt_pend;
            r_pend_valid <= w_nxt_pend_valid;
            data_o       <= w_nxt_char;
            data_valid_o <= (w_nxt_state != S_IDLE);
            busy_o       <= (w_nxt_state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_hex_printer.sv
module tb_uart_hex_printer;

    localparam int LA = 12;
    localparam int LB = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [31:0] val_a;
    logic        vv_a, vr_a, dv_a, rdy_a, busy_a;
    logic [7:0]  data_a;
    logic [7:0]  val_b;
    logic        vv_b, vr_b, dv_b, rdy_b, busy_b;
    logic [7:0]  data_b;

    uart_hex_printer u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .value_i(val_a), .value_valid_i(vv_a), .value_ready_o(vr_a),
        .data_o(data_a), .data_valid_o(dv_a), .ready_i(rdy_a), .busy_o(busy_a)
    );

    uart_hex_printer #(.WIDTH(8), .PREFIX_EN(0), .NEWLINE_EN(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .value_i(val_b), .value_valid_i(vv_b), .value_ready_o(vr_b),
        .data_o(data_b), .data_valid_o(dv_b), .ready_i(rdy_b), .busy_o(busy_b)
    );

    int vectors = 0;
    int miscompares = 0;

    byte unsigned qa[$];
    byte unsigned qb[$];
    byte unsigned log_a[$];
    byte unsigned log_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic byte unsigned hexc(input int n);
        return (n < 10) ? byte'(48 + n) : byte'(65 + n - 10);
    endfunction

    // Model: every accepted value becomes a fixed-length text message queued
    // behind the ones already outstanding; outputs follow from the queue.
    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic [7:0]  held_a = 8'h00, held_b = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            stall_a = 1'b0;
            stall_b = 1'b0;
        end else begin
            chk("valid_a", {31'd0, dv_a}, {31'd0, qa.size() != 0});
            chk("busy_a", {31'd0, busy_a}, {31'd0, qa.size() != 0});
            chk("vready_a", {31'd0, vr_a}, {31'd0, ((qa.size() + LA - 1) / LA) <= 1});
            if (dv_a && qa.size() > 0) chk("data_a", {24'd0, data_a}, {24'd0, qa[0]});
            if (dv_a && stall_a) chk("hold_a", {24'd0, data_a}, {24'd0, held_a});
            stall_a = dv_a && !rdy_a;
            held_a  = data_a;
            if (dv_a && rdy_a && qa.size() > 0) begin
                log_a.push_back(data_a);
                void'(qa.pop_front());
            end
            if (vv_a && vr_a) begin
                qa.push_back(8'h30);
                qa.push_back(8'h78);
                for (int i = 7; i >= 0; i--) qa.push_back(hexc(int'((val_a >> (4 * i)) & 32'hF)));
                qa.push_back(8'h0D);
                qa.push_back(8'h0A);
            end

            chk("valid_b", {31'd0, dv_b}, {31'd0, qb.size() != 0});
            chk("busy_b", {31'd0, busy_b}, {31'd0, qb.size() != 0});
            chk("vready_b", {31'd0, vr_b}, {31'd0, ((qb.size() + LB - 1) / LB) <= 1});
            if (dv_b && qb.size() > 0) chk("data_b", {24'd0, data_b}, {24'd0, qb[0]});
            if (dv_b && stall_b) chk("hold_b", {24'd0, data_b}, {24'd0, held_b});
            stall_b = dv_b && !rdy_b;
            held_b  = data_b;
            if (dv_b && rdy_b && qb.size() > 0) begin
                log_b.push_back(data_b);
                void'(qb.pop_front());
            end
            if (vv_b && vr_b) begin
                for (int i = 1; i >= 0; i--) qb.push_back(hexc(int'((val_b >> (4 * i)) & 8'hF)));
            end
        end
    end

    task automatic chk_log(input string name, input string s, input bit use_b);
        int n;
        n = use_b ? log_b.size() : log_a.size();
        chk({name, "_len"}, n, s.len());
        for (int i = 0; i < s.len(); i++) begin
            if (i < n) chk(name, use_b ? log_b[i] : log_a[i], s[i]);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy_a || busy_b) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy_a || busy_b) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: still busy after %0d cycles", budget);
        end
    endtask

    task automatic offer_a(input logic [31:0] v);
        int n = 0;
        val_a = v;
        vv_a  = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!vr_a && n < 200);
        if (!vr_a) begin
            vectors++;
            miscompares++;
            $display("FAIL offer_a: %0h not accepted", v);
        end
        @(posedge clk); #1;
    endtask

    int busy_cyc;

    initial begin
        rst_n = 1'b0;
        val_a = '0; vv_a = 1'b0; rdy_a = 1'b1;
        val_b = '0; vv_b = 1'b0; rdy_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, data_a}, 32'h00);
        chk("rst_valid", {31'd0, dv_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_vready", {31'd0, vr_a}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // DEADBEEF, sink always ready
        log_a.delete();
        offer_a(32'hDEADBEEF);
        vv_a  = 1'b0;
        val_a = 32'h0BAD0BAD;
        busy_cyc = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy_a) busy_cyc++;
        end
        chk("deadbeef_cycles", busy_cyc, 12);
        chk_log("deadbeef", "0xDEADBEEF\r\n", 1'b0);

        // zero with one ready pulse every 176 cycles
        @(posedge clk); #1;
        log_a.delete();
        rdy_a = 1'b0;
        offer_a(32'h0);
        vv_a = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rdy_a = ((c % 176) == 175);
            @(posedge clk); #1;
            if (log_a.size() == 12 && !busy_a) break;
        end
        rdy_a = 1'b1;
        chk_log("zero_stall", "0x00000000\r\n", 1'b0);

        // back-to-back through the pending slot
        @(posedge clk); #1;
        log_a.delete();
        offer_a(32'h1);
        offer_a(32'h2);
        offer_a(32'h3);
        vv_a = 1'b0;
        wait_idle(100);
        chk_log("b2b", "0x00000001\r\n0x00000002\r\n0x00000003\r\n", 1'b0);

        // reset in the middle of a message
        @(posedge clk); #1;
        log_a.delete();
        offer_a(32'hCAFEF00D);
        vv_a = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (log_a.size() >= 5) break;
            @(posedge clk); #1;
        end
        chk_log("cafe_part", "0xCAF", 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, dv_a}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("mid_rst_vready", {31'd0, vr_a}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        log_a.delete();
        offer_a(32'h12345678);
        vv_a = 1'b0;
        wait_idle(40);
        chk_log("after_rst", "0x12345678\r\n", 1'b0);

        // 8-bit, no prefix, no newline
        @(posedge clk); #1;
        log_b.delete();
        val_b = 8'hA5;
        vv_b  = 1'b1;
        @(posedge clk); #1;
        vv_b  = 1'b0;
        busy_cyc = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy_b) busy_cyc++;
        end
        chk("a5_cycles", busy_cyc, 2);
        chk_log("a5", "A5", 1'b1);
        chk("a5_byte0", (log_b.size() > 0) ? {24'd0, log_b[0]} : 32'hFFFF, 32'h41);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
